// File: rtl/ix_scoreboard.sv
// Issue gate between decode and execute: per-register busy bits, mul/div busy,
// RAW/WAW/structural stalls, and drain-then-issue-alone handling of serial ops.
module ix_scoreboard #(
    parameter int NUM_WB = 2,
    parameter int PERF_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_flush,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [4:0]             dec_rs1,
    input  logic [4:0]             dec_rs2,
    input  logic [4:0]             dec_rd,
    input  logic                   dec_use_rs1,
    input  logic                   dec_use_rs2,
    input  logic                   dec_wb_en,
    input  logic                   dec_muldiv,
    input  logic                   dec_serial,
    output logic                   ix_valid,
    input  logic                   ix_ready,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB-1:0][4:0] wb_rd,
    input  logic                   md_done,
    input  logic                   serial_done,
    output logic                   sb_empty,
    output logic [PERF_W-1:0]      perf_stall_cnt
);
    typedef enum logic {IDLE, SERIAL} state_t;

    state_t            state;
    logic [31:1]       busy_q;
    logic [31:0]       busy;
    logic              md_busy;
    logic [31:1]       clr_vec;
    logic [31:1]       set_vec;
    logic              hazard;
    logic              stall;
    logic              fire;
    logic              stall_cyc;
    logic [PERF_W-1:0] perf_q;

    assign busy     = {busy_q, 1'b0};
    assign sb_empty = (busy_q == '0) && !md_busy;

    // Hazard looks only at registered busy bits: a writeback clear is seen one cycle later.
    assign hazard = (dec_use_rs1 && busy[dec_rs1]) || (dec_use_rs2 && busy[dec_rs2])
                 || (dec_wb_en && busy[dec_rd]) || (dec_muldiv && md_busy);
    assign stall  = hazard || (dec_serial && !sb_empty);

    always_comb begin
        ix_valid  = 1'b0;
        dec_ready = 1'b0;
        if (state == IDLE) begin
            ix_valid  = dec_valid && !stall && !pipe_flush;
            dec_ready = ix_ready && !stall && !pipe_flush;
        end
    end

    assign fire      = ix_valid && ix_ready;
    assign stall_cyc = dec_valid && !dec_ready && !pipe_flush;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int r = 1; r < 32; r++) begin
            set_vec[r] = fire && dec_wb_en && (dec_rd == 5'(r));
            for (int p = 0; p < NUM_WB; p++)
                if (wb_valid[p] && (wb_rd[p] == 5'(r))) clr_vec[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= '0;
            md_busy <= 1'b0;
            perf_q  <= '0;
        end else begin
            busy_q  <= (busy_q & ~clr_vec) | set_vec;
            md_busy <= (md_busy && !md_done) || (fire && dec_muldiv);
            if (stall_cyc && (perf_q != '1))
                perf_q <= perf_q + 1'b1;
            // Flush always returns to IDLE, even over a coincident serial_done.
            if (pipe_flush)
                state <= IDLE;
            else if (state == IDLE && fire && dec_serial)
                state <= SERIAL;
            else if (state == SERIAL && serial_done)
                state <= IDLE;
        end
    end

    assign perf_stall_cnt = perf_q;
endmodule

// File: tb/tb_ix_scoreboard.sv
// Self-checking bench for ix_scoreboard: directed hazard scenarios with literal
// expectations, then randomized traffic compared each cycle against a register-array model.
module tb_ix_scoreboard;
    localparam int NW = 2;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst, pipe_flush, dec_valid, dec_ready;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic dec_use_rs1, dec_use_rs2, dec_wb_en, dec_muldiv, dec_serial;
    logic ix_valid, ix_ready;
    logic [NW-1:0] wb_valid;
    logic [NW-1:0][4:0] wb_rd;
    logic md_done, serial_done, sb_empty;
    logic [PW-1:0] perf_stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: which architectural registers have a write outstanding.
    bit m_busy [32];
    bit m_md;
    bit m_ser;
    int m_perf;
    bit chk_en = 0;

    ix_scoreboard #(.NUM_WB(NW), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_wb_en(dec_wb_en), .dec_muldiv(dec_muldiv), .dec_serial(dec_serial),
        .ix_valid(ix_valid), .ix_ready(ix_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .md_done(md_done), .serial_done(serial_done),
        .sb_empty(sb_empty), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit haz, any_busy, emp, e_ixv, e_rdy, fire;
        haz = (dec_use_rs1 && m_busy[dec_rs1]) || (dec_use_rs2 && m_busy[dec_rs2])
           || (dec_wb_en && m_busy[dec_rd]) || (dec_muldiv && m_md);
        any_busy = 0;
        for (int r = 1; r < 32; r++) any_busy |= m_busy[r];
        emp = !any_busy && !m_md;
        if (m_ser) begin
            e_ixv = 0;
            e_rdy = 0;
        end else begin
            e_ixv = dec_valid && !(haz || (dec_serial && !emp)) && !pipe_flush;
            e_rdy = ix_ready && !(haz || (dec_serial && !emp)) && !pipe_flush;
        end
        if (chk_en) begin
            chk("ix_valid", ix_valid, e_ixv);
            chk("dec_ready", dec_ready, e_rdy);
            chk("sb_empty", sb_empty, emp);
            chk("perf", perf_stall_cnt, m_perf);
        end
        fire = e_ixv && ix_ready;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            m_md = 0; m_ser = 0; m_perf = 0;
            chk_en = 1;
        end else begin
            if (dec_valid && !e_rdy && !pipe_flush && m_perf < (1 << PW) - 1) m_perf++;
            for (int p = 0; p < NW; p++) if (wb_valid[p]) m_busy[wb_rd[p]] = 0;
            if (fire && dec_wb_en && dec_rd != 0) m_busy[dec_rd] = 1;
            if (md_done) m_md = 0;
            if (fire && dec_muldiv) m_md = 1;
            if (pipe_flush) m_ser = 0;
            else if (!m_ser && fire && dec_serial) m_ser = 1;
            else if (m_ser && serial_done) m_ser = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wb, input bit md, input bit ser);
        dec_valid = v; dec_rs1 = 5'(rs1); dec_use_rs1 = u1; dec_rs2 = 5'(rs2); dec_use_rs2 = u2;
        dec_rd = 5'(rd); dec_wb_en = wb; dec_muldiv = md; dec_serial = ser;
    endtask

    initial begin
        int cand[$];
        rst = 1; pipe_flush = 0; ix_ready = 1; wb_valid = '0; wb_rd = '0;
        md_done = 0; serial_done = 0;
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        rst = 0; #1;
        chk("rst_empty", sb_empty, 1); chk("rst_perf", perf_stall_cnt, 0); chk("rst_ixv", ix_valid, 0);

        // RAW on x5, cleared by writeback, issues the cycle after the clear
        dec(1, 0, 0, 0, 0, 5, 1, 0, 0); #1 chk("t1_issue", ix_valid, 1); tick;
        dec(1, 5, 1, 0, 0, 6, 1, 0, 0); #1 chk("t1_raw", ix_valid, 0);
        chk("t1_rdy", dec_ready, 0); chk("t1_notempty", sb_empty, 0); tick;
        wb_valid = 2'b01; wb_rd[0] = 5; #1 chk("t1_nobypass", ix_valid, 0); tick;
        wb_valid = 0; #1 chk("t1_after", ix_valid, 1); chk("t1_perf", perf_stall_cnt, 2); tick;
        dec_valid = 0; wb_valid = 2'b01; wb_rd[0] = 6; tick; wb_valid = 0;

        // mul then div: structural stall until md_done
        dec(1, 0, 0, 0, 0, 0, 0, 1, 0); #1 chk("t2_mul", ix_valid, 1); tick;
        #1 chk("t2_div_s0", ix_valid, 0); tick;
        #1 chk("t2_div_s1", ix_valid, 0); tick;
        md_done = 1; #1 chk("t2_div_s2", ix_valid, 0); tick;
        md_done = 0; #1 chk("t2_div_go", ix_valid, 1); chk("t2_perf", perf_stall_cnt, 5); tick;
        dec_valid = 0; md_done = 1; tick; md_done = 0;

        // serial op drains x5/x6, then blocks the next op until serial_done
        dec(1, 0, 0, 0, 0, 5, 1, 0, 0); tick;
        dec(1, 0, 0, 0, 0, 6, 1, 0, 0); tick;
        dec(1, 0, 0, 0, 0, 0, 0, 0, 1); wb_valid = 2'b01; wb_rd[0] = 5;
        #1 chk("t3_drain0", ix_valid, 0); tick;
        wb_valid = 2'b10; wb_rd[0] = 0; wb_rd[1] = 6; #1 chk("t3_drain1", ix_valid, 0); tick;
        wb_valid = 0; #1 chk("t3_ser_go", ix_valid, 1); tick;
        dec(1, 0, 0, 0, 0, 1, 1, 0, 0); #1 chk("t3_blk", ix_valid, 0); chk("t3_blk_rdy", dec_ready, 0); tick;
        serial_done = 1; #1 chk("t3_done_cyc", ix_valid, 0); tick;
        serial_done = 0; #1 chk("t3_next", ix_valid, 1); chk("t3_perf", perf_stall_cnt, 9); tick;
        dec_valid = 0; wb_valid = 2'b01; wb_rd[0] = 1; tick; wb_valid = 0;

        // writes to x0 never mark busy
        for (int i = 0; i < 4; i++) begin
            dec(1, 0, 1, 0, 1, 0, 1, 0, 0); #1 chk("t4_x0", ix_valid, 1); chk("t4_empty", sb_empty, 1); tick;
        end

        // flush in SERIAL and flush of a ready op
        dec(1, 0, 0, 0, 0, 0, 0, 0, 1); #1 chk("t5_ser", ix_valid, 1); tick;
        dec_valid = 0; pipe_flush = 1; tick;
        pipe_flush = 0; dec(1, 0, 0, 0, 0, 9, 1, 0, 0); #1 chk("t5_idle", ix_valid, 1); tick;
        dec(1, 0, 0, 0, 0, 10, 1, 0, 0); pipe_flush = 1;
        #1 chk("t5_flush_ixv", ix_valid, 0); chk("t5_flush_rdy", dec_ready, 0); tick;
        pipe_flush = 0; dec(1, 9, 1, 0, 0, 0, 0, 0, 0); #1 chk("t5_kept", ix_valid, 0);
        dec(1, 10, 1, 0, 0, 0, 0, 0, 0); #1 chk("t5_noset", ix_valid, 1); tick;
        chk("t5_perf", perf_stall_cnt, 9);

        // dual-port clears, same-reg dual clear, reset mid-stall
        dec_valid = 0; wb_valid = 2'b01; wb_rd[0] = 9; tick; wb_valid = 0;
        dec(1, 0, 0, 0, 0, 7, 1, 0, 0); tick;
        dec(1, 0, 0, 0, 0, 8, 1, 0, 0); tick;
        dec_valid = 0; wb_valid = 2'b11; wb_rd[0] = 7; wb_rd[1] = 8;
        #1 chk("t6_busy", sb_empty, 0); tick;
        wb_valid = 0; #1 chk("t6_clr", sb_empty, 1);
        dec(1, 7, 1, 8, 1, 0, 0, 0, 0); #1 chk("t6_use", ix_valid, 1); tick;
        dec(1, 0, 0, 0, 0, 7, 1, 0, 0); tick;
        dec_valid = 0; wb_valid = 2'b11; wb_rd[0] = 7; wb_rd[1] = 7; tick;
        wb_valid = 0; #1 chk("t6_same", sb_empty, 1);
        dec(1, 0, 0, 0, 0, 11, 1, 0, 0); tick;
        dec(1, 11, 1, 0, 0, 0, 0, 0, 0); #1 chk("t6_stall", ix_valid, 0);
        rst = 1; tick; rst = 0;
        #1 chk("t6_rst_ixv", ix_valid, 1); chk("t6_rst_empty", sb_empty, 1); chk("t6_rst_perf", perf_stall_cnt, 0);
        dec_valid = 0; tick;

        // randomized traffic; clears and completions only for outstanding work
        for (int c = 0; c < 3000; c++) begin
            dec($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
                $urandom_range(1), ($urandom_range(9) == 0) ? $urandom_range(31) : $urandom_range(7),
                $urandom_range(1), $urandom_range(4) == 0, $urandom_range(9) == 0);
            ix_ready    = $urandom_range(4) != 0;
            pipe_flush  = $urandom_range(19) == 0;
            rst         = $urandom_range(199) == 0;
            md_done     = m_md && ($urandom_range(4) == 0);
            serial_done = m_ser && ($urandom_range(3) == 0);
            cand.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(r);
            for (int p = 0; p < NW; p++) begin
                wb_valid[p] = (cand.size() > 0) && ($urandom_range(9) < 3);
                wb_rd[p]    = (cand.size() > 0) ? 5'(cand[$urandom_range(cand.size() - 1)]) : 5'd0;
            end
            tick;
        end
        rst = 0; dec_valid = 0; wb_valid = 0;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
